// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation-control peripheral: register map and
// STATUS bit layout.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF_RESULT  = 2'd0,
        OFF_CONSOLE = 2'd1,
        OFF_CYCLES  = 2'd2,
        OFF_STATUS  = 2'd3
    } reg_off_e;

    localparam int unsigned ST_DONE      = 0;
    localparam int unsigned ST_PASS      = 1;
    localparam int unsigned ST_TIMEOUT   = 2;
    localparam int unsigned ST_OVERFLOW  = 3;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_COUNT_W   = 8;

    // Expand byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/sim_ctrl_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push while full is accepted only
// when a pop happens in the same cycle.
module sim_ctrl_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [7:0]       count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fill;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                     (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign fill    = wr_ptr - rd_ptr;
    assign count   = 8'(fill);
    // Masked so the head reads 0 whenever nothing is queued, including after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/sim_ctrl_device.sv
// Bus-attached simulation-control peripheral: result register, console FIFO,
// cycle counter and watchdog behind a 16-byte register window.
module sim_ctrl_device
    import sim_ctrl_pkg::*;
#(
    parameter logic [31:0]  BASE_ADDR      = 32'hffff_fff0,
    parameter int unsigned  TIMEOUT_CYCLES = 100000,
    parameter int unsigned  FIFO_DEPTH     = 16,
    parameter int unsigned  CNT_WIDTH      = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        done,
    output logic        pass,
    output logic        timeout
);

    logic                 hit;
    reg_off_e             off;
    logic                 wr_hit;
    logic                 rd_hit;
    logic                 result_set;
    logic                 wd_fire;
    logic                 push_req;
    logic                 pop;
    logic                 ovf_set;
    logic                 ovf_clr;
    logic                 done_next;
    logic                 overflow;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_count;
    logic [CNT_WIDTH-1:0] counter;
    logic [31:0]          status;
    logic [31:0]          rd_mux;
    logic                 unused_bits;

    assign unused_bits = ^bus_address[1:0];

    // Address decode and per-register strobes.
    assign hit        = (bus_address[31:4] == BASE_ADDR[31:4]);
    assign off        = reg_off_e'(bus_address[3:2]);
    assign wr_hit     = bus_write_enable && hit;
    assign rd_hit     = bus_read_enable && hit;
    assign result_set = wr_hit && (off == OFF_RESULT) && (|bus_byte_enable) && !done;
    assign wd_fire    = (TIMEOUT_CYCLES != 0) && (counter == CNT_WIDTH'(TIMEOUT_CYCLES)) &&
                        !done && !result_set;
    assign push_req   = wr_hit && (off == OFF_CONSOLE) && bus_byte_enable[0];
    assign pop        = con_valid && con_ready;
    assign ovf_set    = push_req && fifo_full && !pop;
    assign ovf_clr    = wr_hit && (off == OFF_STATUS) && bus_byte_enable[0] &&
                        bus_write_data[ST_OVERFLOW];
    assign done_next  = done || result_set || wd_fire;
    assign con_valid  = !fifo_empty;

    sim_ctrl_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (bus_write_data[7:0]),
        .rdata (con_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                                 = '0;
        status[ST_DONE]                        = done;
        status[ST_PASS]                        = pass;
        status[ST_TIMEOUT]                     = timeout;
        status[ST_OVERFLOW]                    = overflow;
        status[ST_COUNT_LSB +: ST_COUNT_W]     = fifo_count;
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CYCLES: rd_mux = counter[31:0];
            OFF_STATUS: rd_mux = status;
            default:    rd_mux = '0;
        endcase
    end

    // Result/watchdog flags; a result write beats the watchdog in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else if (result_set) begin
            done    <= 1'b1;
            pass    <= |(bus_write_data & be_mask(bus_byte_enable));
        end else if (wd_fire) begin
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    // Counter freezes on the same edge that sets done and saturates at all-ones.
    always_ff @(posedge clock) begin
        if (reset)                            counter <= '0;
        else if (!done_next && (counter != '1)) counter <= counter + CNT_WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)       bus_read_data <= '0;
        else if (rd_hit) bus_read_data <= rd_mux;
    end

endmodule

// File: tb/tb_sim_ctrl_device.sv
// Randomized bench for sim_ctrl_device against a queue-based reference model,
// with directed result, watchdog, console, overflow and reset scenarios.
module tb_sim_ctrl_device;

    localparam logic [31:0] BASE  = 32'hffff_fff0;
    localparam int unsigned TO    = 60;
    localparam int unsigned DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        done;
    logic        pass;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    // Reference model state
    byte unsigned q[$];
    bit          m_done, m_pass, m_tmo, m_ovf;
    logic [31:0] m_cnt, m_rdata;

    sim_ctrl_device #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH),
        .CNT_WIDTH      (32)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_byte_enable  (bus_byte_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_read_data    (bus_read_data),
        .con_valid        (con_valid),
        .con_data         (con_data),
        .con_ready        (con_ready),
        .done             (done),
        .pass             (pass),
        .timeout          (timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                              input bit rd, input bit wr, input bit rdy, input bit rst);
        bit          hit, rset, wd, push, pop;
        logic [1:0]  off;
        logic [31:0] mask, st;
        if (rst) begin
            q.delete();
            m_done = 0; m_pass = 0; m_tmo = 0; m_ovf = 0;
            m_cnt = 0; m_rdata = 0;
            return;
        end
        hit  = (a[31:4] == BASE[31:4]);
        off  = a[3:2];
        pop  = (q.size() != 0) && rdy;
        st   = {16'h0, 8'(q.size()), 4'h0, m_ovf, m_tmo, m_pass, m_done};
        if (rd && hit) m_rdata = (off == 2'd2) ? m_cnt : (off == 2'd3) ? st : 32'h0;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        rset = wr && hit && off == 2'd0 && be != 4'h0 && !m_done;
        wd   = (m_cnt == TO) && !m_done && !rset;
        push = wr && hit && off == 2'd1 && be[0];
        if (wr && hit && off == 2'd3 && be[0] && d[3]) m_ovf = 0;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(d[7:0]);
            else                  m_ovf = 1;
        end
        if (rset) m_pass = |(d & mask);
        if (wd) begin m_pass = 0; m_tmo = 1; end
        m_done = m_done | rset | wd;
        if (!m_done && m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
    endtask

    task automatic compare_all();
        chk("con_valid", 32'(con_valid), 32'(q.size() != 0));
        chk("con_data", 32'(con_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk("done", 32'(done), 32'(m_done));
        chk("pass", 32'(pass), 32'(m_pass));
        chk("timeout", 32'(timeout), 32'(m_tmo));
        chk("read_data", bus_read_data, m_rdata);
    endtask

    // One clock: drive at negedge, advance model, compare just after the edge.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input bit rd, input bit wr, input bit rdy, input bit rst);
        @(negedge clock);
        bus_address      = a;
        bus_write_data   = d;
        bus_byte_enable  = be;
        bus_read_enable  = rd;
        bus_write_enable = wr;
        con_ready        = rdy;
        reset            = rst;
        model_step(a, d, be, rd, wr, rdy, rst);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        cyc(32'h0, 32'h0, 4'h0, 0, 0, rdy, 0);
    endtask

    task automatic do_reset();
        cyc(32'h0, 32'h0, 4'h0, 0, 0, 0, 1);
    endtask

    task automatic wr_reg(input logic [1:0] off, input logic [31:0] d, input bit rdy);
        cyc(BASE | {28'h0, off, 2'b00}, d, 4'hf, 0, 1, rdy, 0);
    endtask

    task automatic rd_reg(input logic [1:0] off);
        cyc(BASE | {28'h0, off, 2'b00}, 32'h0, 4'h0, 1, 0, 0, 0);
    endtask

    initial begin
        byte unsigned hello[5];
        logic [31:0]  a, d;
        logic [1:0]   off;
        int           r;

        hello = '{8'h48, 8'h45, 8'h4c, 8'h4c, 8'h4f};
        reset = 1'b1; bus_address = '0; bus_write_data = '0; bus_byte_enable = '0;
        bus_read_enable = 0; bus_write_enable = 0; con_ready = 0;

        // Result write with nonzero data, then a later write of 0 is ignored
        do_reset();
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdata", bus_read_data, 32'h0);
        wr_reg(2'd0, 32'h1, 0);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_pass", 32'(pass), 32'h1);
        chk("t1_timeout", 32'(timeout), 32'h0);
        wr_reg(2'd0, 32'h0, 0);
        chk("t1_pass_sticky", 32'(pass), 32'h1);

        // Result write of zero, STATUS reads 1
        do_reset();
        wr_reg(2'd0, 32'h0, 0);
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_pass", 32'(pass), 32'h0);
        rd_reg(2'd3);
        chk("t2_status", bus_read_data, 32'h1);

        // Watchdog with no writes, bounded wait
        do_reset();
        for (int i = 0; i < 200 && !done; i++) idle(0);
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_timeout", 32'(timeout), 32'h1);
        chk("t3_pass", 32'(pass), 32'h0);
        rd_reg(2'd2);
        chk("t3_cycles", bus_read_data, TO);
        idle(0); idle(0);
        rd_reg(2'd2);
        chk("t3_cycles_frozen", bus_read_data, TO);

        // Console: push HELLO while blocked, then drain
        do_reset();
        foreach (hello[i]) wr_reg(2'd1, 32'(hello[i]), 0);
        chk("t4_valid", 32'(con_valid), 32'h1);
        chk("t4_head", 32'(con_data), 32'h48);
        idle(0);
        chk("t4_head_held", 32'(con_data), 32'h48);
        foreach (hello[i]) begin
            chk("t4_stream", 32'(con_data), 32'(hello[i]));
            idle(1);
        end
        chk("t4_empty", 32'(con_valid), 32'h0);

        // Overflow, then full+pop push, then W1C clear
        do_reset();
        for (int i = 0; i <= int'(DEPTH); i++) wr_reg(2'd1, 32'(8'h30 + i), 0);
        rd_reg(2'd3);
        chk("t5_status_ovf", bus_read_data, {16'h0, 8'(DEPTH), 8'h08});
        wr_reg(2'd1, 32'h7a, 1);
        wr_reg(2'd3, 32'h8, 0);
        rd_reg(2'd3);
        chk("t5_status_clr", bus_read_data, {16'h0, 8'(DEPTH), 8'h00});

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) wr_reg(2'd1, 32'(8'h61 + i), 0);
        wr_reg(2'd0, 32'h5, 0);
        rd_reg(2'd3);
        do_reset();
        chk("t6_valid", 32'(con_valid), 32'h0);
        chk("t6_data", 32'(con_data), 32'h0);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_rdata", bus_read_data, 32'h0);
        rd_reg(2'd3);
        chk("t6_status", bus_read_data, 32'h0);
        rd_reg(2'd2);
        chk("t6_cycles", bus_read_data, 32'h1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r   = int'($urandom_range(0, 99));
            off = 2'($urandom_range(0, 3));
            if (off == 2'd0 && $urandom_range(0, 9) != 0) off = 2'd1;
            if (r < 85)      a = BASE | {28'h0, off, 2'($urandom)};
            else if (r < 92) a = BASE - 32'h10 + {28'h0, off, 2'b00};
            else             a = $urandom;
            d = $urandom;
            cyc(a, d, 4'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
